// File: rtl/matrix_mult_pkg.sv
// rtl/matrix_mult_pkg.sv - shared types and width helpers for the matrix multiply engine
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } mmState_e;

    // Row-major flat position of element [i][j] in an n x n matrix
    function automatic int elemIdx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    // Width of one element product
    function automatic int prodWidth(input int w);
        return 2 * w;
    endfunction

    // Width of a full n-term dot product, wide enough that no carry is lost
    function automatic int sumWidth(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_product_unit.sv
// rtl/dot_product_unit.sv - N-lane combinational multiply-accumulate of one row and one column
module dot_product_unit
    import matrix_mult_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic [N*W-1:0]              aRow,
    input  logic [N*W-1:0]              bCol,
    output logic [sumWidth(W, N)-1:0]   dotSum
);

    localparam int PW = prodWidth(W);
    localparam int SW = sumWidth(W, N);

    logic [PW-1:0] prod [N];

    // One full-width multiplier per lane
    always_comb begin
        for (int m = 0; m < N; m++) begin
            prod[m] = PW'(aRow[m*W +: W]) * PW'(bCol[m*W +: W]);
        end
    end

    // Sum of the lane products at full width
    always_comb begin
        dotSum = '0;
        for (int m = 0; m < N; m++) begin
            dotSum = dotSum + SW'(prod[m]);
        end
    end

endmodule

// File: rtl/matrix_mult_engine.sv
// rtl/matrix_mult_engine.sv - streaming N x N matrix multiplier with wrap/saturate and chain mode
module matrix_mult_engine
    import matrix_mult_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [N*N*W-1:0]     dataIn,
    input  logic                 satMode,
    input  logic                 chainEn,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [N*N*OW-1:0]    dataOut,
    output logic                 ovf
);

    localparam int SW       = sumWidth(W, N);
    localparam int IW       = $clog2(N);
    localparam bit CHAIN_OK = (OW == W);

    mmState_e state, nextState;

    logic [N*N*W-1:0]  aReg, bReg;
    logic [N*N*OW-1:0] cReg;
    logic [IW-1:0]     rowIdx, colIdx;
    logic              satReg, ovfReg;

    logic [N*W-1:0]    aRow, bCol;
    logic [SW-1:0]     dotSum;
    logic [OW-1:0]     elemVal;
    logic              elemOvf;
    logic [N*N*W-1:0]  cAsA;
    logic              inFire, outFire, lastElem;

    assign inFire   = inValid & inReady;
    assign outFire  = outValid & outReady;
    assign lastElem = (rowIdx == IW'(N - 1)) && (colIdx == IW'(N - 1));
    assign dataOut  = cReg;
    assign ovf      = ovfReg;

    // State register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= LOAD_A;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and handshake outputs; input and output phases never overlap
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            LOAD_A: begin
                inReady = 1'b1;
                if (inValid) nextState = LOAD_B;
            end
            LOAD_B: begin
                inReady = 1'b1;
                if (inValid) nextState = COMPUTE;
            end
            COMPUTE: begin
                if (lastElem) nextState = OUTPUT;
            end
            OUTPUT: begin
                outValid = 1'b1;
                if (outReady) nextState = (chainEn && CHAIN_OK) ? LOAD_B : LOAD_A;
            end
            default: nextState = LOAD_A;
        endcase
    end

    // Pick row rowIdx of A and column colIdx of B for the dot-product lanes
    always_comb begin
        for (int m = 0; m < N; m++) begin
            aRow[m*W +: W] = aReg[elemIdx(int'(rowIdx), m, N)*W +: W];
            bCol[m*W +: W] = bReg[elemIdx(m, int'(colIdx), N)*W +: W];
        end
    end

    dot_product_unit #(
        .N (N),
        .W (W)
    ) dotUnit (
        .aRow   (aRow),
        .bCol   (bCol),
        .dotSum (dotSum)
    );

    // Overflow detection and wrap/saturate reduction to the output width
    always_comb begin
        elemOvf = (dotSum >> OW) != '0;
        elemVal = (satReg && elemOvf) ? {OW{1'b1}} : OW'(dotSum);
    end

    // C reinterpreted at input width so it can become the next A in chain mode
    always_comb begin
        for (int e = 0; e < N*N; e++) begin
            cAsA[e*W +: W] = W'(cReg[e*OW +: OW]);
        end
    end

    // Matrix registers, element counter and sticky overflow
    always_ff @(posedge clk) begin
        if (!rstN) begin
            aReg   <= '0;
            bReg   <= '0;
            cReg   <= '0;
            rowIdx <= '0;
            colIdx <= '0;
            satReg <= 1'b0;
            ovfReg <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (inFire) aReg <= dataIn;
                end
                LOAD_B: begin
                    if (inFire) begin
                        bReg   <= dataIn;
                        satReg <= satMode;
                        ovfReg <= 1'b0;
                        rowIdx <= '0;
                        colIdx <= '0;
                    end
                end
                COMPUTE: begin
                    cReg[elemIdx(int'(rowIdx), int'(colIdx), N)*OW +: OW] <= elemVal;
                    if (elemOvf) ovfReg <= 1'b1;
                    if (colIdx == IW'(N - 1)) begin
                        colIdx <= '0;
                        rowIdx <= rowIdx + 1'b1;
                    end else begin
                        colIdx <= colIdx + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (outFire && chainEn && CHAIN_OK) aReg <= cAsA;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb/tb_matrix_mult_engine.sv - directed self-checking bench for matrix_mult_engine
module tb_matrix_mult_engine;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int OW = 16;
    localparam int MW = N*N*W;

    logic           clk = 1'b0;
    logic           rstN;
    logic           inValid;
    logic           inReady;
    logic [MW-1:0]  dataIn;
    logic           satMode;
    logic           chainEn;
    logic           outValid;
    logic           outReady;
    logic [MW-1:0]  dataOut;
    logic           ovf;

    int checks   = 0;
    int failures = 0;

    int matA [16] = '{5,8,9,2, 7,3,8,4, 6,5,4,3, 8,5,7,6};
    int matB [16] = '{11,14,19,18, 6,9,3,5, 12,10,15,14, 1,3,5,7};
    int matC [16] = '{213,238,264,270, 195,217,282,281, 147,178,204,210, 208,245,302,309};
    int ident[16] = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};

    always #5 clk = ~clk;

    matrix_mult_engine #(.N(N), .W(W), .OW(OW)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .dataIn   (dataIn),
        .satMode  (satMode),
        .chainEn  (chainEn),
        .outValid (outValid),
        .outReady (outReady),
        .dataOut  (dataOut),
        .ovf      (ovf)
    );

    task automatic checkVal(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] packMat(input int m [16]);
        logic [MW-1:0] r;
        int v;
        r = '0;
        for (int e = 0; e < 16; e++) begin
            v = m[e];
            r[e*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] fillMat(input logic [15:0] v);
        logic [MW-1:0] r;
        for (int e = 0; e < 16; e++) r[e*16 +: 16] = v;
        return r;
    endfunction

    // Offer one beat and hold it until accepted; returns just after the accepting edge
    task automatic sendBeat(input logic [MW-1:0] d);
        int n;
        @(negedge clk);
        dataIn  = d;
        inValid = 1'b1;
        n = 0;
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) checkVal("inReady_wait", {255'd0, inReady}, 1);
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    // Rising edges from the B handshake until outValid is seen
    task automatic waitLatency(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (outValid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic takeOutput(input logic chain);
        int n;
        @(negedge clk);
        outReady = 1'b1;
        chainEn  = chain;
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!outValid) checkVal("outValid_wait", {255'd0, outValid}, 1);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        chainEn  = 1'b0;
    endtask

    task automatic runProduct(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                              input logic sat, input logic [MW-1:0] expC, input logic expOvf);
        int lat;
        sendBeat(a);
        satMode = sat;
        sendBeat(b);
        satMode = ~sat;
        waitLatency(lat);
        checkVal({tag, "_lat"}, lat, 16);
        checkVal({tag, "_data"}, dataOut, expC);
        checkVal({tag, "_ovf"}, {255'd0, ovf}, {255'd0, expOvf});
    endtask

    initial begin
        int lat;
        int seen;
        rstN     = 1'b0;
        inValid  = 1'b0;
        dataIn   = '0;
        satMode  = 1'b0;
        chainEn  = 1'b0;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkVal("rst_inReady", {255'd0, inReady}, 1);
        checkVal("rst_outValid", {255'd0, outValid}, 0);
        checkVal("rst_dataOut", dataOut, 0);
        checkVal("rst_ovf", {255'd0, ovf}, 0);

        // Basic product
        runProduct("basic", packMat(matA), packMat(matB), 1'b0, packMat(matC), 1'b0);
        checkVal("basic_elem00", {240'd0, dataOut[15:0]}, 16'h00D5);
        takeOutput(1'b0);
        @(negedge clk);
        checkVal("post_outValid", {255'd0, outValid}, 0);
        checkVal("post_inReady", {255'd0, inReady}, 1);
        checkVal("post_hold", dataOut, packMat(matC));

        // Wrap and saturate
        runProduct("wrap", fillMat(16'hFFFF), fillMat(16'h0001), 1'b0, fillMat(16'hFFFC), 1'b1);
        takeOutput(1'b0);
        runProduct("sat", fillMat(16'hFFFF), fillMat(16'h0001), 1'b1, fillMat(16'hFFFF), 1'b1);
        takeOutput(1'b0);

        // Back-pressure with a competing A beat
        runProduct("bp", packMat(matA), packMat(matB), 1'b0, packMat(matC), 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkVal("bp_outValid", {255'd0, outValid}, 1);
            checkVal("bp_data", dataOut, packMat(matC));
            checkVal("bp_inReady", {255'd0, inReady}, 0);
            inValid = 1'b1;
            dataIn  = packMat(ident);
        end
        inValid = 1'b0;
        takeOutput(1'b0);

        // Chain: I x A, then reuse the result with B2 = I
        runProduct("chain1", packMat(ident), packMat(matA), 1'b0, packMat(matA), 1'b0);
        takeOutput(1'b1);
        @(negedge clk);
        checkVal("chain_inReady", {255'd0, inReady}, 1);
        satMode = 1'b0;
        sendBeat(packMat(ident));
        waitLatency(lat);
        checkVal("chain2_lat", lat, 16);
        checkVal("chain2_data", dataOut, packMat(matA));
        takeOutput(1'b0);

        // Reset while computing element 7
        sendBeat(packMat(matB));
        sendBeat(packMat(matA));
        repeat (7) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkVal("midrst_outValid", {255'd0, outValid}, 0);
        checkVal("midrst_dataOut", dataOut, 0);
        checkVal("midrst_ovf", {255'd0, ovf}, 0);
        checkVal("midrst_inReady", {255'd0, inReady}, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        checkVal("midrst_no_out", seen, 0);
        runProduct("after_rst", packMat(matA), packMat(matB), 1'b0, packMat(matC), 1'b0);
        takeOutput(1'b0);

        // Idle gaps between beats
        sendBeat(packMat(matA));
        repeat (3) @(negedge clk);
        satMode = 1'b0;
        sendBeat(packMat(matB));
        waitLatency(lat);
        checkVal("gap_lat", lat, 16);
        checkVal("gap_data", dataOut, packMat(matC));
        checkVal("gap_ovf", {255'd0, ovf}, 0);
        takeOutput(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
